lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store initiator in the MEM stage; the requester side of the data RAM interface.
- Accepts one load or store per handshake from the pipeline and drives a word-addressed memory port with byte enables.
- Waits for the memory acknowledge, then returns load data sign- or zero-extended.
- Stalls the pipeline while a transfer is outstanding and aborts on timeout.

Parameters:
- ADDR_W, 6, word-address width on the memory side; 64 words.
- TIMEOUT, 16, maximum cycles in BUSY before the transfer is aborted; must be ≥2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- lsu_valid  in  1  pipeline request valid.
- lsu_ready  out  1  block can accept a request.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_type  in  3  size code: 000 word; 001 half; 010 byte; 101 half unsigned (load only); 110 byte unsigned (load only).
- lsu_addr  in  32  byte address.
- lsu_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  32  extended load data; 0 for stores.
- rsp_err  out  1  qualifies rsp_valid: misaligned access or timeout.
- stall  out  1  asserted while a request is outstanding.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  word address, lsu_addr[ADDR_W+1:2].
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_ack  in  1  memory completion, one cycle.
- mem_rdata  in  32  read word, valid with mem_ack.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0 except lsu_ready = 1.
  - Timeout counter 0.
  - Reset mid-transfer drops the request immediately; no rsp_valid is produced.
- IDLE:
  - lsu_ready = 1.
  - Accept when lsu_valid & lsu_ready.
  - Register we, type, addr[1:0], word address, be and aligned wdata.
  - Go to BUSY next cycle.
- Byte enables:
  - word: 1111.
  - half: 0011 << addr[1:0], with addr[0] = 0.
  - byte: 0001 << addr[1:0].
- Write data: wdata is replicated per lane: half is {2{wdata[15:0]}}, byte is {4{wdata[7:0]}}.
- Misalignment:
  - word with addr[1:0] ≠ 0, or half with addr[0] = 1, is misaligned.
  - A misaligned request is accepted, issues no mem_req, and goes to DONE with the error flag set.
  - Store types 101 and 110 are treated as misaligned (illegal).
- BUSY:
  - mem_req = 1, with stable mem_we/addr/be/wdata.
  - Counter increments each cycle.
  - On mem_ack: capture mem_rdata, deassert mem_req in the next cycle, go to DONE.
  - If the counter reaches TIMEOUT-1 without ack: go to DONE with the error flag set; mem_req drops.
  - An ack arriving in the same cycle as the timeout wins (no error).
- DONE (one cycle):
  - rsp_valid = 1 and rsp_err = error flag.
  - rsp_data:
    - word: rdata.
    - half: selected half sign-extended (signed type) or zero-extended.
    - byte: selected byte sign- or zero-extended.
    - store or error: 0.
  - Then return to IDLE.
- stall = lsu_valid in IDLE is not a stall; stall = 1 in BUSY and DONE.
- lsu_ready = 0 in BUSY and DONE.
- Latency, aligned load with zero-wait memory (ack in the first BUSY cycle): accept at T0, mem_req at T1, ack at T1, rsp_valid at T2. Back-to-back accept is possible at T3.
- mem_ack outside BUSY is ignored.

Optional Feature:
- Macro LSU_ALIGN_CHECK_EN.
- Defined: misalignment detection as described above; rsp_err flags misaligned accesses.
- Not defined:
  - Address bits below the access size are forced to 0: word addr[1:0] = 00, half addr[0] = 0.
  - The access proceeds to memory normally and rsp_err reports only timeouts.

Test Plan:
- LW addr 0x10, memory returns 0xDEADBEEF after 3-cycle delay → mem_addr = 4, mem_be = 1111, rsp_valid one cycle after ack, rsp_data = 0xDEADBEEF, rsp_err = 0.
- LB addr 0x13, rdata = 0x80FF7F01 → mem_be = 1000, rsp_data = 0xFFFFFF80. LBU from the same address → 0x00000080.
- SH addr 0x06, wdata = 0x1234ABCD → mem_we = 1, mem_be = 1100, mem_wdata = 0xABCDABCD; rsp_valid with rsp_data = 0.
- LW addr 0x02 with LSU_ALIGN_CHECK_EN defined → no mem_req, rsp_valid + rsp_err at T2. With the macro undefined → mem_addr = 0, normal load.
- No ack, TIMEOUT = 16 → mem_req high for exactly 16 cycles, then rsp_valid + rsp_err; a subsequent request works normally.
- rst_n pulled low during BUSY → mem_req, stall and rsp_valid drop asynchronously; lsu_ready = 1 after release; a late ack is ignored.

Source files
------------

// File: rtl/lsu_mem_initiator_if.sv
// Purpose: bundles the pipeline request/response and data-RAM port of the LSU initiator.
// Latency: n/a (wiring only).
// Backpressure: the pipeline side uses lsu_valid/lsu_ready; the memory side holds mem_req until mem_ack.
//
// Signals
//   lsu_valid/lsu_ready/lsu_we/lsu_type/lsu_addr/lsu_wdata : pipeline request
//   rsp_valid/rsp_data/rsp_err/stall                       : pipeline response and stall
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata/mem_ack/mem_rdata : word-addressed data RAM port
// Modports: master = the initiator block, slave = its environment (pipeline + memory).
interface lsu_mem_initiator_if #(
    parameter int ADDR_W = 6
);
    logic              lsu_valid;
    logic              lsu_ready;
    logic              lsu_we;
    logic [2:0]        lsu_type;
    logic [31:0]       lsu_addr;
    logic [31:0]       lsu_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        input  lsu_valid, lsu_we, lsu_type, lsu_addr, lsu_wdata, mem_ack, mem_rdata,
        output lsu_ready, rsp_valid, rsp_data, rsp_err, stall,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output lsu_valid, lsu_we, lsu_type, lsu_addr, lsu_wdata, mem_ack, mem_rdata,
        input  lsu_ready, rsp_valid, rsp_data, rsp_err, stall,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Purpose: MEM-stage load/store initiator driving a word-addressed data RAM with byte enables.
// Latency: accept T0, mem_req T1, earliest rsp_valid T2 (zero-wait memory); next accept at T3.
// Backpressure: lsu_ready low and stall high from accept until the response cycle ends; aborts after TIMEOUT busy cycles.
//
// Ports: clk, rst_n (async active-low), bus (lsu_mem_initiator_if.master: pipeline + memory sides).
// Optional feature macro LSU_ALIGN_CHECK_EN: when defined, misaligned or illegal requests are
// answered with rsp_err and never reach memory; when undefined, low address bits are forced to
// the access size and rsp_err reports only timeouts.
module lsu_mem_initiator #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    lsu_mem_initiator_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [2:0]        type_q;
    logic [1:0]        off_q;
    logic              err_q;

    logic              lsu_ready_q;
    logic              stall_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_data_q;
    logic              rsp_err_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;

    // Request decode: lane offset, error, byte enables and lane-replicated write data.
    logic              req_half;
    logic              req_byte;
    logic              req_err;
    logic [1:0]        req_off;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;

    always_comb begin
        req_half = (bus.lsu_type[1:0] == 2'b01);
        req_byte = (bus.lsu_type[1:0] == 2'b10);
`ifdef LSU_ALIGN_CHECK_EN
        req_off = bus.lsu_addr[1:0];
        case (bus.lsu_type)
            3'b000:         req_err = (req_off != 2'b00);
            3'b001, 3'b101: req_err = req_off[0];
            3'b010, 3'b110: req_err = 1'b0;
            default:        req_err = 1'b1;
        endcase
        // Unsigned size codes only make sense for loads.
        if (bus.lsu_we && bus.lsu_type[2]) begin
            req_err = 1'b1;
        end
`else
        req_err = 1'b0;
        if (req_byte) begin
            req_off = bus.lsu_addr[1:0];
        end else if (req_half) begin
            req_off = {bus.lsu_addr[1], 1'b0};
        end else begin
            req_off = 2'b00;
        end
`endif
        if (req_byte) begin
            req_be    = 4'b0001 << req_off;
            req_wdata = {4{bus.lsu_wdata[7:0]}};
        end else if (req_half) begin
            req_be    = 4'b0011 << req_off;
            req_wdata = {2{bus.lsu_wdata[15:0]}};
        end else begin
            req_be    = 4'b1111;
            req_wdata = bus.lsu_wdata;
        end
    end

    // Load data extraction from the word being returned this cycle.
    logic [15:0] sel_half;
    logic [7:0]  sel_byte;
    logic        ld_sign;
    logic [31:0] ld_data;

    always_comb begin
        sel_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (off_q)
            2'd0:    sel_byte = bus.mem_rdata[7:0];
            2'd1:    sel_byte = bus.mem_rdata[15:8];
            2'd2:    sel_byte = bus.mem_rdata[23:16];
            default: sel_byte = bus.mem_rdata[31:24];
        endcase
        ld_sign = ~type_q[2];
        if (we_q) begin
            ld_data = 32'd0;
        end else if (type_q[1:0] == 2'b10) begin
            ld_data = {{24{ld_sign & sel_byte[7]}}, sel_byte};
        end else if (type_q[1:0] == 2'b01) begin
            ld_data = {{16{ld_sign & sel_half[15]}}, sel_half};
        end else begin
            ld_data = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            type_q      <= 3'd0;
            off_q       <= 2'd0;
            err_q       <= 1'b0;
            lsu_ready_q <= 1'b1;
            stall_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.lsu_valid && lsu_ready_q) begin
                        we_q        <= bus.lsu_we;
                        type_q      <= bus.lsu_type;
                        off_q       <= req_off;
                        err_q       <= req_err;
                        mem_we_q    <= bus.lsu_we;
                        mem_addr_q  <= bus.lsu_addr[ADDR_W+1:2];
                        mem_be_q    <= req_be;
                        mem_wdata_q <= req_wdata;
                        // A rejected access spends its BUSY cycle without touching memory.
                        mem_req_q   <= ~req_err;
                        cnt         <= '0;
                        lsu_ready_q <= 1'b0;
                        stall_q     <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (err_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= 32'd0;
                        state       <= DONE;
                    end else if (bus.mem_ack) begin
                        // Ack beats the timeout when both land in the same cycle.
                        mem_req_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= ld_data;
                        state       <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        mem_req_q   <= 1'b0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= 32'd0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= 32'd0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_be_q    <= 4'd0;
                    mem_wdata_q <= 32'd0;
                    err_q       <= 1'b0;
                    lsu_ready_q <= 1'b1;
                    stall_q     <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.lsu_ready = lsu_ready_q;
    assign bus.stall     = stall_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Byte-address bits above the RAM's reach are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.lsu_addr[31:ADDR_W+2];
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Purpose: randomized self-checking bench for lsu_mem_initiator against a byte-level reference model.
// Latency: checks accept-to-response cycle counts and mem_req duration per transfer.
// Backpressure: exercises memory wait states, timeouts, back-to-back requests and reset mid-transfer.
module tb_lsu_mem_initiator;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst_n;

    lsu_mem_initiator_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_mem_initiator #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    logic [31:0] mem_model [64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request starting at a negedge; returns at the negedge after the response cycle.
    task automatic do_req(input string tag, input bit we, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input int delay, input bit noack);
        int          nb, off, exp_lat, exp_req, req_cnt, lat;
        bit          m_err, seen, first;
        logic [3:0]  m_be;
        logic [31:0] m_wd, rd, exp_data, mask, v;
        logic [5:0]  wa;

        nb = (t[1:0] == 2'b01) ? 2 : (t[1:0] == 2'b10) ? 1 : 4;
`ifdef LSU_ALIGN_CHECK_EN
        off   = int'(a[1:0]);
        m_err = !(t inside {3'd0, 3'd1, 3'd2, 3'd5, 3'd6}) || (we && t[2]) || ((off % nb) != 0);
`else
        off   = int'(a[1:0]) - (int'(a[1:0]) % nb);
        m_err = 1'b0;
`endif
        m_be = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) m_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
        wa = a[7:2];
        rd = mem_model[wa];

        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
        v = (rd >> (8*off)) & mask;
        if (!t[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
        exp_data = (we || m_err || noack) ? 32'd0 : v;
        exp_lat  = m_err ? 2 : noack ? TIMEOUT + 1 : delay + 2;
        exp_req  = m_err ? 0 : noack ? TIMEOUT : delay + 1;

        bus.lsu_valid = 1'b1;
        bus.lsu_we    = we;
        bus.lsu_type  = t;
        bus.lsu_addr  = a;
        bus.lsu_wdata = wd;
        chk({tag, "/ready"}, 32'(bus.lsu_ready), 32'd1);
        @(posedge clk);

        seen = 1'b0; first = 1'b1; req_cnt = 0; lat = 0;
        for (int cyc = 1; cyc <= TIMEOUT + 8 && !seen; cyc++) begin
            @(negedge clk);
            bus.lsu_valid = 1'b0;
            bus.lsu_addr  = $urandom;
            bus.lsu_wdata = $urandom;
            if (cyc == 1) begin
                chk({tag, "/stall"}, 32'(bus.stall), 32'd1);
                chk({tag, "/busy_ready"}, 32'(bus.lsu_ready), 32'd0);
            end
            if (bus.rsp_valid) begin
                seen = 1'b1;
                lat  = cyc;
                chk({tag, "/rsp_data"}, bus.rsp_data, exp_data);
                chk({tag, "/rsp_err"}, 32'(bus.rsp_err), 32'(m_err || noack));
                bus.mem_ack   = ($urandom_range(0, 3) == 0);
                bus.mem_rdata = $urandom;
            end else if (bus.mem_req) begin
                if (first) begin
                    first = 1'b0;
                    chk({tag, "/mem_we"}, 32'(bus.mem_we), 32'(we));
                    chk({tag, "/mem_addr"}, 32'(bus.mem_addr), 32'(wa));
                    chk({tag, "/mem_be"}, 32'(bus.mem_be), 32'(m_be));
                    if (we) chk({tag, "/mem_wdata"}, bus.mem_wdata, m_wd);
                end
                bus.mem_ack   = (!noack && req_cnt == delay);
                bus.mem_rdata = bus.mem_ack ? rd : $urandom;
                req_cnt++;
            end else begin
                bus.mem_ack = 1'b0;
            end
        end
        chk({tag, "/rsp_seen"}, 32'(seen), 32'd1);
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/req_cycles"}, 32'(req_cnt), 32'(exp_req));

        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk({tag, "/rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "/ready_again"}, 32'(bus.lsu_ready), 32'd1);
        chk({tag, "/stall_clr"}, 32'(bus.stall), 32'd0);

        if (we && !m_err && !noack) begin
            for (int i = 0; i < 4; i++) if (m_be[i]) mem_model[wa][8*i +: 8] = m_wd[8*i +: 8];
        end
    endtask

    logic [2:0] types [5];

    initial begin
        types = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6};
        for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
        bus.lsu_valid = 1'b0; bus.lsu_we = 1'b0; bus.lsu_type = 3'd0;
        bus.lsu_addr  = 32'd0; bus.lsu_wdata = 32'd0;
        bus.mem_ack   = 1'b0; bus.mem_rdata = 32'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst/ready", 32'(bus.lsu_ready), 32'd1);
        chk("rst/stall", 32'(bus.stall), 32'd0);
        chk("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst/rsp_data", bus.rsp_data, 32'd0);
        chk("rst/rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst/mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst/mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst/mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst/mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst/mem_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        mem_model[4] = 32'hDEAD_BEEF;
        do_req("lw_0x10", 1'b0, 3'b000, 32'h10, 32'h0, 3, 1'b0);
        mem_model[4] = 32'h80FF_7F01;
        do_req("lb_0x13", 1'b0, 3'b010, 32'h13, 32'h0, 0, 1'b0);
        do_req("lbu_0x13", 1'b0, 3'b110, 32'h13, 32'h0, 1, 1'b0);
        do_req("sh_0x06", 1'b1, 3'b001, 32'h06, 32'h1234_ABCD, 2, 1'b0);
        do_req("lw_0x02", 1'b0, 3'b000, 32'h02, 32'h0, 0, 1'b0);
        do_req("timeout", 1'b0, 3'b000, 32'h40, 32'h0, 0, 1'b1);
        do_req("after_to", 1'b0, 3'b001, 32'h42, 32'h0, 0, 1'b0);
        do_req("ack_last", 1'b0, 3'b101, 32'h84, 32'h0, TIMEOUT - 1, 1'b0);
        do_req("sb_unsigned", 1'b1, 3'b110, 32'h21, 32'hA5A5_5A5A, 0, 1'b0);

        // Reset while a transfer is outstanding.
        bus.lsu_valid = 1'b1; bus.lsu_we = 1'b0; bus.lsu_type = 3'b000; bus.lsu_addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        bus.lsu_valid = 1'b0;
        chk("mid_rst/req_before", 32'(bus.mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst/mem_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst/stall", 32'(bus.stall), 32'd0);
        chk("mid_rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst/ready", 32'(bus.lsu_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("late_ack/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("late_ack/mem_req", 32'(bus.mem_req), 32'd0);
        chk("late_ack/ready", 32'(bus.lsu_ready), 32'd1);
        do_req("post_rst", 1'b0, 3'b000, 32'h20, 32'h0, 1, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            int  r, dly;
            bit  na;
            r   = $urandom_range(0, 15);
            na  = (r == 0);
            dly = (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 3);
            do_req("rand", 1'($urandom_range(0, 1)), types[$urandom_range(0, 4)],
                   $urandom, $urandom, dly, na);
            repeat ($urandom_range(0, 2)) begin
                bus.mem_ack = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                chk("idle/rsp_valid", 32'(bus.rsp_valid), 32'd0);
            end
            bus.mem_ack = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end
endmodule
